// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//
// Control FSM for a shift-add sequential multiplier datapath made of a
// multiplicand register (Mx), a shifting multiplier register (My) and an
// accumulator (Acc). One multiplication runs LOAD, then one ADD/SHIFT pair
// per multiplier bit, then a single-cycle DONE pulse. In signed mode the
// multiplier MSB carries negative weight, so the last ADD subtracts Mx.
//
// Parameters
//   MY_W   multiplier width = number of add/shift iterations (2..64)
//   CNT_W  bit-counter width, 2**CNT_W >= MY_W
//
// Ports
//   CLK       in   rising-edge clock
//   RESET     in   synchronous active-high reset
//   START     in   request a multiplication (only looked at in IDLE)
//   SIGNED    in   operand mode, captured during LOAD (1 = two's complement)
//   MY_LSB    in   current LSB of the My register
//   load_Mx   out  load multiplicand register
//   load_My   out  load multiplier register
//   shift_My  out  shift My right by one
//   clr_Acc   out  clear accumulator
//   load_Acc  out  Acc <= Acc + Mx (or - Mx with sub_Acc)
//   sub_Acc   out  qualifies load_Acc as a subtraction
//   shift_in  out  shift Acc:My right, Acc LSB into My MSB
//   BUSY      out  high from LOAD through the last SHIFT
//   DONE      out  one-cycle pulse, product valid
//   BIT_CNT   out  current iteration index
//
// Optional build macro
//   SEQ_MULT_ZERO_SKIP_EN  when defined, an ADD that sees MY_LSB=0 (and is not
//                          the last bit) performs the shift itself and stays
//                          in ADD, so zero multiplier bits take one cycle.
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
  parameter int MY_W  = 9,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic             MY_LSB,
  output logic             load_Mx,
  output logic             load_My,
  output logic             shift_My,
  output logic             clr_Acc,
  output logic             load_Acc,
  output logic             sub_Acc,
  output logic             shift_in,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] BIT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MY_W - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sgn_q;
  logic             sgn_next;
  logic             last_bit;

  assign last_bit = (cnt == LAST_IDX);
  assign BIT_CNT  = cnt;

  // State, bit counter and captured operand mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      sgn_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sgn_q <= sgn_next;
    end
  end

  // Next-state and strobe decode. Strobes come from the registered state;
  // only load_Acc/sub_Acc (and the optional zero skip) look at MY_LSB.
  // While RESET is high every strobe is forced low so nothing reaches the
  // datapath in the reset cycle, even if the FSM was mid-operation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sgn_next   = sgn_q;
    load_Mx    = 1'b0;
    load_My    = 1'b0;
    shift_My   = 1'b0;
    clr_Acc    = 1'b0;
    load_Acc   = 1'b0;
    sub_Acc    = 1'b0;
    shift_in   = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end
      end

      S_LOAD: begin
        load_Mx    = 1'b1;
        load_My    = 1'b1;
        clr_Acc    = 1'b1;
        BUSY       = 1'b1;
        cnt_next   = '0;
        sgn_next   = SIGNED;
        state_next = S_ADD;
      end

      S_ADD: begin
        BUSY     = 1'b1;
        load_Acc = MY_LSB;
        // The MSB of a two's-complement multiplier has weight -2**(MY_W-1).
        sub_Acc  = MY_LSB & sgn_q & last_bit;
`ifdef SEQ_MULT_ZERO_SKIP_EN
        if (!MY_LSB && !last_bit) begin
          shift_My   = 1'b1;
          shift_in   = 1'b1;
          cnt_next   = cnt + 1'b1;
          state_next = S_ADD;
        end else begin
          state_next = S_SHIFT;
        end
`else
        state_next = S_SHIFT;
`endif
      end

      S_SHIFT: begin
        BUSY     = 1'b1;
        shift_My = 1'b1;
        shift_in = 1'b1;
        if (last_bit) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = cnt + 1'b1;
          state_next = S_ADD;
        end
      end

      S_DONE: begin
        DONE       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (RESET) begin
      load_Mx  = 1'b0;
      load_My  = 1'b0;
      shift_My = 1'b0;
      clr_Acc  = 1'b0;
      load_Acc = 1'b0;
      sub_Acc  = 1'b0;
      shift_in = 1'b0;
      BUSY     = 1'b0;
      DONE     = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
//
// Bench for seq_mult_ctrl with MY_W=9 driving a behavioural shift-add
// datapath (16-bit Mx). Products are compared against plain multiplication,
// latency against the closed-form cycle count, and per-operation strobe
// summaries (which bits were added, where a subtract happened, shift count)
// against what the multiplier bits imply.
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;

  localparam int MY_W  = 9;
  localparam int CNT_W = 6;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             START;
  logic             SIGNED;
  logic             MY_LSB;
  logic             load_Mx;
  logic             load_My;
  logic             shift_My;
  logic             clr_Acc;
  logic             load_Acc;
  logic             sub_Acc;
  logic             shift_in;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] BIT_CNT;

  int total = 0;
  int bad   = 0;

  seq_mult_ctrl #(.MY_W(MY_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SIGNED(SIGNED), .MY_LSB(MY_LSB),
    .load_Mx(load_Mx), .load_My(load_My), .shift_My(shift_My), .clr_Acc(clr_Acc),
    .load_Acc(load_Acc), .sub_Acc(sub_Acc), .shift_in(shift_in),
    .BUSY(BUSY), .DONE(DONE), .BIT_CNT(BIT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural datapath reacting to the controller strobes.
  logic [15:0]     op_mx = '0;
  logic [MY_W-1:0] op_my = '0;
  logic            op_sgn = 1'b0;
  logic [15:0]     dp_mx = '0;
  logic [MY_W-1:0] dp_my = '0;
  longint          dp_acc = 0;
  longint          mx_val;

  assign mx_val = op_sgn ? longint'({{48{dp_mx[15]}}, dp_mx}) : longint'({48'b0, dp_mx});
  assign MY_LSB = dp_my[0];

  always @(posedge CLK) begin
    if (load_Mx) dp_mx <= op_mx;
    if (load_My) dp_my <= op_my;
    if (clr_Acc) dp_acc <= 0;
    else if (load_Acc) dp_acc <= sub_Acc ? dp_acc - mx_val : dp_acc + mx_val;
    if (shift_in) begin
      dp_my  <= {dp_acc[0], dp_my[MY_W-1:1]};
      dp_acc <= dp_acc >>> 1;
    end
  end

  // Reference values from the arithmetic meaning of an operation.
  function automatic longint refProduct(input logic [15:0] mx, input logic [MY_W-1:0] my,
                                        input logic sgn);
    longint a;
    longint b;
    a = sgn ? longint'({{48{mx[15]}}, mx}) : longint'({48'b0, mx});
    b = sgn ? longint'({{(64-MY_W){my[MY_W-1]}}, my}) : longint'({{(64-MY_W){1'b0}}, my});
    return a * b;
  endfunction

  // Edges from the START edge to the edge that raises DONE.
  function automatic int expLatency(input logic [MY_W-1:0] my);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic [MY_W-2:0] low;
    low = my[MY_W-2:0];
    return MY_W + 2 + $countones(low);
`else
    return 2 * MY_W + 1 + 0 * int'(my[0]);
`endif
  endfunction

  function automatic logic [8:0] strobes();
    return {load_Mx, load_My, shift_My, clr_Acc, load_Acc, sub_Acc, shift_in, BUSY, DONE};
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Results of the most recent applyStimulus call.
  longint r_prod;
  int     r_edges;
  int     r_la_mask;
  int     r_sub_mask;
  int     r_shifts;
  int     r_loads;
  int     r_busy_bad;
  int     r_excl_bad;
  int     r_cnt_done;
  int     r_busy_done;
  bit     r_done_seen;

  // Starts one multiplication from IDLE and observes it until DONE.
  task automatic applyStimulus(input logic [15:0] mx, input logic [MY_W-1:0] my,
                               input logic sgn, input bit hold);
    @(negedge CLK);
    op_mx  = mx;
    op_my  = my;
    op_sgn = sgn;
    SIGNED = sgn;
    START  = 1'b1;
    @(posedge CLK);
    r_edges = 0; r_la_mask = 0; r_sub_mask = 0; r_shifts = 0; r_loads = 0;
    r_busy_bad = 0; r_excl_bad = 0; r_done_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!hold) START = 1'b0;
      if (DONE) begin
        r_done_seen = 1'b1;
        break;
      end
      if (load_Mx) r_loads++;
      if (shift_My) r_shifts++;
      if (load_Acc && BIT_CNT < MY_W) r_la_mask |= (1 << BIT_CNT);
      if (sub_Acc && BIT_CNT < MY_W) r_sub_mask |= (1 << BIT_CNT);
      if (!BUSY) r_busy_bad++;
      if ((int'(load_Acc) + int'(shift_in) + int'(load_My)) > 1 ||
          (sub_Acc && !load_Acc) || (sub_Acc && !op_sgn))
        r_excl_bad++;
      @(posedge CLK);
      r_edges++;
    end
    r_cnt_done  = int'(BIT_CNT);
    r_busy_done = int'(BUSY);
    r_prod      = dp_acc * 512 + longint'({55'b0, dp_my});
    if (!r_done_seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no DONE, expected DONE within 200 cycles");
    end
  endtask

  task automatic checkOp(input string tag, input logic [MY_W-1:0] my, input logic sgn,
                         input longint exp_prod);
    checkOutput({tag, "_prod"}, r_prod, exp_prod);
    checkOutput({tag, "_latency"}, r_edges, expLatency(my));
    checkOutput({tag, "_add_bits"}, r_la_mask, int'(my));
    checkOutput({tag, "_sub_bits"}, r_sub_mask, (sgn && my[MY_W-1]) ? (1 << (MY_W-1)) : 0);
    checkOutput({tag, "_shifts"}, r_shifts, MY_W);
    checkOutput({tag, "_loads"}, r_loads, 1);
    checkOutput({tag, "_busy_gaps"}, r_busy_bad, 0);
    checkOutput({tag, "_exclusive"}, r_excl_bad, 0);
    checkOutput({tag, "_cnt_at_done"}, r_cnt_done, MY_W - 1);
    checkOutput({tag, "_busy_at_done"}, r_busy_done, 0);
  endtask

  typedef struct {
    logic [15:0]     mx;
    logic [MY_W-1:0] my;
    logic            sgn;
    longint          prod;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int found;
    int dones;
    int extra_loads;
    int edges2;

    vecs[0] = '{16'h0003, 9'h005, 1'b0, 15};
    vecs[1] = '{16'h0005, 9'h1FF, 1'b1, -5};
    vecs[2] = '{16'hFFFF, 9'h1FF, 1'b0, 33488385};
    vecs[3] = '{16'h8000, 9'h100, 1'b1, 8388608};
    vecs[4] = '{16'h0007, 9'h100, 1'b1, -1792};
    vecs[5] = '{16'hFFFF, 9'h003, 1'b1, -3};
    vecs[6] = '{16'h1234, 9'h000, 1'b0, 0};
    vecs[7] = '{16'h0002, 9'h1FF, 1'b0, 1022};
    vecs[8] = '{16'h0003, 9'h001, 1'b0, 3};

    RESET  = 1'b1;
    START  = 1'b0;
    SIGNED = 1'b0;

    // Reset held for three edges, then ten quiet cycles with START low.
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_strobes", longint'(strobes()), 0);
    end
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("idle_strobes", longint'(strobes()), 0);
      checkOutput("idle_cnt", longint'(BIT_CNT), 0);
    end

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].mx, vecs[i].my, vecs[i].sgn, 1'b0);
      checkOp($sformatf("vec%0d", i), vecs[i].my, vecs[i].sgn, vecs[i].prod);
    end

`ifdef SEQ_MULT_ZERO_SKIP_EN
    applyStimulus(16'h0003, 9'h001, 1'b0, 1'b0);
    checkOutput("skip_latency", r_edges, 12);
    checkOutput("skip_shifts", r_shifts, 9);
`endif

    // START held high: the next LOAD appears only after DONE and a turn in IDLE.
    applyStimulus(16'h0003, 9'h005, 1'b0, 1'b1);
    checkOp("hold_first", 9'h005, 1'b0, 15);
    @(negedge CLK);
    checkOutput("hold_idle_busy", longint'(BUSY), 0);
    checkOutput("hold_idle_loadmx", longint'(load_Mx), 0);
    @(negedge CLK);
    checkOutput("hold_restart_loadmx", longint'(load_Mx), 1);
    checkOutput("hold_restart_busy", longint'(BUSY), 1);
    extra_loads = 0;
    edges2 = 0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      edges2++;
      @(negedge CLK);
      if (DONE) begin
        dones = 1;
        break;
      end
      if (load_Mx) extra_loads++;
    end
    START = 1'b0;
    checkOutput("hold_second_done", dones, 1);
    checkOutput("hold_second_latency", edges2, expLatency(9'h005));
    checkOutput("hold_no_restart", extra_loads, 0);
    checkOutput("hold_second_prod", dp_acc * 512 + longint'({55'b0, dp_my}), 15);

    // Reset in the SHIFT of bit 4 abandons the operation.
    @(negedge CLK);
    op_mx  = 16'h0003;
    op_my  = 9'h015;
    op_sgn = 1'b0;
    SIGNED = 1'b0;
    START  = 1'b1;
    @(posedge CLK);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (shift_My && !load_Acc && BIT_CNT == 4) begin
        found = 1;
        break;
      end
    end
    checkOutput("midrst_reached_shift4", found, 1);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_strobes", longint'(strobes()), 0);
    checkOutput("midrst_cnt", longint'(BIT_CNT), 0);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_after_strobes", longint'(strobes()), 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);
    applyStimulus(16'h0003, 9'h015, 1'b0, 1'b0);
    checkOp("midrst_rerun", 9'h015, 1'b0, 63);

    // Randomised operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [15:0]     mx;
      logic [MY_W-1:0] my;
      logic            sgn;
      mx  = 16'($urandom);
      my  = MY_W'($urandom_range(0, (1 << MY_W) - 1));
      sgn = 1'($urandom_range(0, 1));
      applyStimulus(mx, my, sgn, 1'b0);
      checkOp($sformatf("rnd%0d", i), my, sgn, refProduct(mx, my, sgn));
    end

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
